dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate cache sitting directly upstream of the cacheline adaptor.
- Accepts 32-bit CPU word requests and holds tag, valid, dirty and data arrays internally.
- On a miss it issues whole 256-bit line reads and writebacks on the line-side memory interface; the adaptor serialises these into 8 x 32-bit pmem beats.

Parameters:
- SETS, 16, number of lines; power of two, >= 2. Index width IW = log2(SETS); offset width 5 (32-byte line); tag width 27-IW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_read  in  1  word read request; held until cpu_resp.
- cpu_write  in  1  word write request; held until cpu_resp.
- cpu_addr  in  32  byte address; bits [4:2] select the word in the line.
- cpu_wdata  in  32  write data.
- cpu_byte_en  in  4  byte enables for writes.
- cpu_rdata  out  32  read data; valid only while cpu_resp=1, otherwise 0.
- cpu_resp  out  1  one-cycle completion pulse.
- mem_read  out  1  line read request to the adaptor.
- mem_write  out  1  line write request to the adaptor.
- mem_address  out  32  line-aligned address; bits [4:0]=0.
- mem_wdata  out  256  writeback line.
- mem_byte_enable  out  32  all ones while mem_write=1, else 0.
- mem_rdata  in  256  fill line; valid when mem_resp=1.
- mem_resp  in  1  line transfer complete, one-cycle pulse.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all valid and dirty bits = 0; all outputs = 0. The data and tag arrays are not reset.
- Reset mid-transfer: mem_read and mem_write drop immediately. A late mem_resp arriving after reset is ignored.
- States:
  - IDLE: if cpu_read or cpu_write, latch addr, wdata, byte_en and op, then go to COMPARE. If both are asserted, the request is a write.
  - COMPARE: hit = valid[idx] && tag[idx]==latched tag.
    - Hit, read: cpu_resp=1 and cpu_rdata = line word[addr[4:2]] in the same cycle; go to IDLE.
    - Hit, write: cpu_resp=1; merge the enabled bytes into the word at the clock edge; if byte_en!=0, set dirty[idx]; go to IDLE.
    - Miss with valid&&dirty: go to WRITEBACK.
    - Miss otherwise: go to ALLOCATE.
  - WRITEBACK: mem_write=1, mem_address={tag[idx],idx,5'b0}, mem_wdata=line[idx]. All are held stable until mem_resp. On mem_resp, clear dirty[idx] and go to ALLOCATE.
  - ALLOCATE: mem_read=1, mem_address={latched tag,idx,5'b0}, held until mem_resp. On mem_resp: line[idx]=mem_rdata, tag updated, valid=1, dirty=0; go to COMPARE, which then hits.
- mem_read and mem_write are never both 1. mem_resp is ignored in IDLE and COMPARE.
- Latency, counting the request cycle as t0:
  - Hit: cpu_resp at t1.
  - Clean miss: mem_read from t2; cpu_resp one cycle after mem_resp.
  - Dirty miss: mem_write from t2; mem_read starts the cycle after the writeback mem_resp.
- cpu_resp is asserted only in COMPARE on a hit. The CPU must deassert the request or present a new one the cycle after cpu_resp. The controller re-samples only in IDLE, so a held request is not double-serviced within that cycle.
- Index = addr[5+IW-1:5]. Tag = addr[31:5+IW]. Word select = addr[4:2]. Addr bits [1:0] are ignored.

Test Plan:
- Cold read 0x0000_0040, SETS=16, memory returns line with word0=0xDEAD_BEEF one cycle after mem_read -> mem_address=0x40, cpu_rdata=0xDEADBEEF with cpu_resp; a repeat read hits with cpu_resp at t1 and no mem_read.
- Write 0x0000_0044 data 0x11223344 byte_en=4'b0101 after fill (old word 0xAAAA_AAAA) -> no mem traffic; readback gives 0xAA22AA44; dirty set.
- Read 0x0000_0240 (same index 2, different tag) with the index dirty -> mem_write with mem_address=0x40, mem_wdata word1=0xAA22AA44, mem_byte_enable all ones; then mem_read at 0x240; cpu_resp after fill; mem_read and mem_write never overlap.
- Write with byte_en=0 on a clean hit line -> cpu_resp at t1; data unchanged; a subsequent conflict miss issues no writeback.
- Assert rst=0 during ALLOCATE, then pulse mem_resp after release -> mem_read is 0 during reset; controller stays IDLE; all lines miss afterwards.
- cpu_read and cpu_write both 1 -> treated as write; cpu_resp is a single pulse per request.

Source files
------------

// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dm_cache_ctrl
// Description : Direct-mapped write-back/write-allocate cache controller that
//               issues whole-line fills and writebacks to a cacheline adaptor.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_cache_ctrl #(
    parameter int SETS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    input  logic [3:0]   cpu_byte_en,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_resp,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_address,
    output logic [255:0] mem_wdata,
    output logic [31:0]  mem_byte_enable,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 27 - IW;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [31:2]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          write_q;

    logic [255:0]  data_q  [SETS];
    logic [TW-1:0] tag_q   [SETS];
    logic [SETS-1:0] valid_q;
    logic [SETS-1:0] dirty_q;

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [2:0]    wsel;
    logic [255:0]  line;
    logic [255:0]  merged;
    logic          hit;
    logic          unused_addr_bits;

    // Byte offset is irrelevant for word accesses.
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign idx  = addr_q[5+IW-1:5];
    assign tag  = addr_q[31:5+IW];
    assign wsel = addr_q[4:2];
    assign line = data_q[idx];
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        merged = line;
        for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
                merged[{wsel, 2'(b), 3'b000} +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cpu_resp        = 1'b0;
        cpu_rdata       = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        case (state_q)
            IDLE: begin
                if (cpu_read || cpu_write) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    cpu_resp = 1'b1;
                    if (!write_q) begin
                        cpu_rdata = line[{wsel, 5'b00000} +: 32];
                    end
                    state_d = IDLE;
                end else if (valid_q[idx] && dirty_q[idx]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_write       = 1'b1;
                mem_address     = {tag_q[idx], idx, 5'b00000};
                mem_wdata       = line;
                mem_byte_enable = '1;
                if (mem_resp) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_read    = 1'b1;
                mem_address = {tag, idx, 5'b00000};
                if (mem_resp) begin
                    state_d = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture and line status bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (state_q == IDLE && (cpu_read || cpu_write)) begin
                addr_q  <= cpu_addr[31:2];
                wdata_q <= cpu_wdata;
                be_q    <= cpu_byte_en;
                write_q <= cpu_write;
            end
            if (state_q == COMPARE && hit && write_q && (be_q != 4'b0000)) begin
                dirty_q[idx] <= 1'b1;
            end
            if (state_q == WRITEBACK && mem_resp) begin
                dirty_q[idx] <= 1'b0;
            end
            if (state_q == ALLOCATE && mem_resp) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // Data and tag storage carry no reset; valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (state_q == COMPARE && hit && write_q) begin
            data_q[idx] <= merged;
        end
        if (state_q == ALLOCATE && mem_resp) begin
            data_q[idx] <= mem_rdata;
            tag_q[idx]  <= tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_cache_ctrl
// Description : Directed bench for dm_cache_ctrl with a line-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_cache_ctrl;

    logic         clk;
    logic         rst;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [3:0]   cpu_byte_en;
    logic [31:0]  cpu_rdata;
    logic         cpu_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [31:0]  mem_byte_enable;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    dm_cache_ctrl #(.SETS(16)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_byte_en     (cpu_byte_en),
        .cpu_rdata       (cpu_rdata),
        .cpu_resp        (cpu_resp),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [255:0] mem_store [logic [31:0]];
    logic         mem_auto;
    int           rd_count, wb_count;
    logic [31:0]  last_rd_addr, last_wb_addr, last_wb_be;
    logic [255:0] last_wb_data;
    int           wb_resp_cyc, rd_start_cyc, req_cyc;
    logic         m_wr;
    logic [31:0]  m_addr, m_be;
    logic [255:0] m_wd;
    logic         overlap_seen, unstable_seen;
    logic         prev_rd, prev_wr;
    logic [31:0]  prev_addr;
    logic [255:0] prev_wd;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line memory: answers one cycle after a request is first seen.
    always begin
        @(negedge clk);
        if (mem_auto && rst && (mem_read || mem_write)) begin
            m_wr   = mem_write;
            m_addr = mem_address;
            m_wd   = mem_wdata;
            m_be   = mem_byte_enable;
            @(negedge clk);
            if (m_wr) begin
                mem_store[m_addr] = m_wd;
                wb_count++;
                last_wb_addr = m_addr;
                last_wb_data = m_wd;
                last_wb_be   = m_be;
                wb_resp_cyc  = cyc;
            end else begin
                mem_rdata    = mem_store.exists(m_addr) ? mem_store[m_addr] : '0;
                rd_count++;
                last_rd_addr = m_addr;
            end
            mem_resp = 1'b1;
            @(negedge clk);
            mem_resp = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mem_read && mem_write) overlap_seen = 1'b1;
        if (mem_read && !prev_rd) rd_start_cyc = cyc;
        if (mem_write && prev_wr && (mem_address != prev_addr || mem_wdata != prev_wd))
            unstable_seen = 1'b1;
        if (mem_read && prev_rd && mem_address != prev_addr) unstable_seen = 1'b1;
        prev_rd   = mem_read;
        prev_wr   = mem_write;
        prev_addr = mem_address;
        prev_wd   = mem_wdata;
    end

    // Entered and left just after a rising edge; lat is the cycle of cpu_resp.
    task automatic cpu_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be,
                           output logic [31:0] rdata, output int lat);
        req_cyc     = cyc;
        cpu_read    = rd;
        cpu_write   = wr;
        cpu_addr    = addr;
        cpu_wdata   = wd;
        cpu_byte_en = be;
        lat         = -1;
        rdata       = '0;
        for (int n = 0; n < 100 && lat < 0; n++) begin
            @(negedge clk);
            if (cpu_resp) begin
                lat   = n;
                rdata = cpu_rdata;
            end
        end
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        check("resp_seen", 256'(lat >= 0), 256'(1));
        @(negedge clk);
        check("resp_single_pulse", 256'(cpu_resp), 256'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] rdat;
    int          lat, rc0, wc0;

    initial begin
        rst = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; cpu_byte_en = '0; mem_rdata = '0; mem_resp = 1'b0;
        mem_auto = 1'b1; rd_count = 0; wb_count = 0;
        last_rd_addr = '0; last_wb_addr = '0; last_wb_be = '0; last_wb_data = '0;
        wb_resp_cyc = 0; rd_start_cyc = 0; req_cyc = 0;
        overlap_seen = 1'b0; unstable_seen = 1'b0;
        prev_rd = 1'b0; prev_wr = 1'b0; prev_addr = '0; prev_wd = '0;
        mem_store[32'h0000_0040] = {{7{32'hAAAA_AAAA}}, 32'hDEAD_BEEF};
        mem_store[32'h0000_0240] = {{7{32'h5555_5555}}, 32'h2400_0000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_resp", 256'(cpu_resp), 256'(0));
        check("rst_mem_read", 256'(mem_read), 256'(0));
        check("rst_mem_write", 256'(mem_write), 256'(0));
        check("rst_mem_address", 256'(mem_address), 256'(0));
        check("rst_cpu_rdata", 256'(cpu_rdata), 256'(0));
        check("rst_mem_be", 256'(mem_byte_enable), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Cold read miss, then the same word hits.
        rc0 = rd_count;
        cpu_req(1'b1, 1'b0, 32'h0000_0040, '0, 4'h0, rdat, lat);
        check("cold_rdata", 256'(rdat), 256'(32'hDEAD_BEEF));
        check("cold_lat", 256'(lat), 256'(4));
        check("cold_fill_addr", 256'(last_rd_addr), 256'(32'h0000_0040));
        check("cold_read_start", 256'(rd_start_cyc - req_cyc), 256'(2));
        check("cold_read_count", 256'(rd_count - rc0), 256'(1));
        rc0 = rd_count;
        cpu_req(1'b1, 1'b0, 32'h0000_0040, '0, 4'h0, rdat, lat);
        check("hit_rdata", 256'(rdat), 256'(32'hDEAD_BEEF));
        check("hit_lat", 256'(lat), 256'(1));
        check("hit_no_mem", 256'(rd_count - rc0), 256'(0));

        // Partial write hit merges bytes 0 and 2.
        rc0 = rd_count; wc0 = wb_count;
        cpu_req(1'b0, 1'b1, 32'h0000_0044, 32'h1122_3344, 4'b0101, rdat, lat);
        check("wr_hit_lat", 256'(lat), 256'(1));
        cpu_req(1'b1, 1'b0, 32'h0000_0044, '0, 4'h0, rdat, lat);
        check("wr_merge_rdata", 256'(rdat), 256'(32'hAA22_AA44));
        check("wr_no_mem", 256'(rd_count - rc0 + wb_count - wc0), 256'(0));

        // Dirty conflict miss: writeback of 0x40 then fill of 0x240.
        rc0 = rd_count; wc0 = wb_count;
        cpu_req(1'b1, 1'b0, 32'h0000_0240, '0, 4'h0, rdat, lat);
        check("dirty_wb_count", 256'(wb_count - wc0), 256'(1));
        check("dirty_wb_addr", 256'(last_wb_addr), 256'(32'h0000_0040));
        check("dirty_wb_data", last_wb_data,
              {{6{32'hAAAA_AAAA}}, 32'hAA22_AA44, 32'hDEAD_BEEF});
        check("dirty_wb_be", 256'(last_wb_be), 256'(32'hFFFF_FFFF));
        check("dirty_fill_addr", 256'(last_rd_addr), 256'(32'h0000_0240));
        check("dirty_read_after_wb", 256'(rd_start_cyc - wb_resp_cyc), 256'(1));
        check("dirty_rdata", 256'(rdat), 256'(32'h2400_0000));
        check("dirty_lat", 256'(lat), 256'(7));

        // Zero byte-enable write leaves data and the line clean.
        cpu_req(1'b0, 1'b1, 32'h0000_0248, 32'hFFFF_FFFF, 4'b0000, rdat, lat);
        check("be0_lat", 256'(lat), 256'(1));
        cpu_req(1'b1, 1'b0, 32'h0000_0248, '0, 4'h0, rdat, lat);
        check("be0_unchanged", 256'(rdat), 256'(32'h5555_5555));
        rc0 = rd_count; wc0 = wb_count;
        cpu_req(1'b1, 1'b0, 32'h0000_0048, '0, 4'h0, rdat, lat);
        check("be0_no_wb", 256'(wb_count - wc0), 256'(0));
        check("be0_miss_lat", 256'(lat), 256'(4));
        check("be0_miss_rdata", 256'(rdat), 256'(32'hAAAA_AAAA));

        // Reset while ALLOCATE is waiting, followed by a stray mem_resp.
        mem_auto    = 1'b0;
        cpu_read    = 1'b1;
        cpu_addr    = 32'h0000_0080;
        cpu_byte_en = 4'h0;
        repeat (3) @(negedge clk);
        check("alloc_mem_read", 256'(mem_read), 256'(1));
        check("alloc_addr", 256'(mem_address), 256'(32'h0000_0080));
        #2;
        rst = 1'b0;
        #1;
        check("rst_drops_read", 256'(mem_read), 256'(0));
        check("rst_drops_addr", 256'(mem_address), 256'(0));
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        mem_rdata = {8{32'h7777_7777}};
        mem_resp  = 1'b1;
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        @(negedge clk);
        check("late_resp_read", 256'(mem_read), 256'(0));
        check("late_resp_write", 256'(mem_write), 256'(0));
        check("late_resp_cpu", 256'(cpu_resp), 256'(0));
        @(posedge clk);
        #1;
        mem_auto = 1'b1;
        rc0 = rd_count; wc0 = wb_count;
        cpu_req(1'b1, 1'b0, 32'h0000_0040, '0, 4'h0, rdat, lat);
        check("post_rst_miss_lat", 256'(lat), 256'(4));
        check("post_rst_fill", 256'(rd_count - rc0), 256'(1));
        check("post_rst_no_wb", 256'(wb_count - wc0), 256'(0));
        check("post_rst_rdata", 256'(rdat), 256'(32'hDEAD_BEEF));

        // Read and write together count as a write.
        cpu_req(1'b1, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'b1111, rdat, lat);
        check("both_lat", 256'(lat), 256'(1));
        cpu_req(1'b1, 1'b0, 32'h0000_0040, '0, 4'h0, rdat, lat);
        check("both_written", 256'(rdat), 256'(32'h0BAD_F00D));
        wc0 = wb_count;
        cpu_req(1'b1, 1'b0, 32'h0000_0240, '0, 4'h0, rdat, lat);
        check("both_dirty_wb", 256'(wb_count - wc0), 256'(1));
        check("both_wb_data", last_wb_data,
              {{6{32'hAAAA_AAAA}}, 32'hAA22_AA44, 32'h0BAD_F00D});
        check("both_rdata", 256'(rdat), 256'(32'h2400_0000));

        check("no_rd_wr_overlap", 256'(overlap_seen), 256'(0));
        check("mem_req_stable", 256'(unstable_seen), 256'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
